// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: requester channels plus multiplexed RTC bus of the sequencer.
//   slave  : sequencer side (takes req/rnw/addr_in/wdata_in/bus_in, drives the rest)
//   master : requesters + RTC device side
interface rtc_bus_sequencer_if #(
  parameter int NUM_CH = 5,
  parameter int DW = 8
);
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    rnw;
  logic [NUM_CH*DW-1:0] addr_in;
  logic [NUM_CH*DW-1:0] wdata_in;
  logic [NUM_CH-1:0]    grant;
  logic                 done;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic [DW-1:0]        bus_out;
  logic                 bus_oe;
  logic [DW-1:0]        bus_in;
  logic                 cs_n;
  logic                 rd_n;
  logic                 wr_n;
  logic                 aod;
  modport slave (
    input  req, rnw, addr_in, wdata_in, bus_in,
    output grant, done, rdata, busy, bus_out, bus_oe, cs_n, rd_n, wr_n, aod
  );
  modport master (
    output req, rnw, addr_in, wdata_in, bus_in,
    input  grant, done, rdata, busy, bus_out, bus_oe, cs_n, rd_n, wr_n, aod
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: arbitrates NUM_CH requesters and runs address+data cycles on a multiplexed RTC bus.
//   clk, Reset (sync, active-high)
//   bus.req/rnw/addr_in/wdata_in : per-channel requests, ch i at [i*DW +: DW]
//   bus.grant/done/busy/rdata    : one-hot owner, completion pulse, activity, read result
//   bus.bus_out/bus_oe/bus_in    : RTC data bus (tristate split), bus.cs_n/rd_n/wr_n strobes, bus.aod phase
//   RTC_RR_ARB_EN defined selects round-robin arbitration; otherwise fixed priority, ch 0 highest.
module rtc_bus_sequencer #(
  parameter int NUM_CH = 5,
  parameter int DW = 8,
  parameter int T_SETUP = 1,
  parameter int T_STROBE = 4,
  parameter int T_HOLD = 1,
  parameter int T_GAP = 2
) (
  input logic clk,
  input logic Reset,
  rtc_bus_sequencer_if.slave bus
);
  localparam logic [3:0] IDLE = 4'd0, A_SET = 4'd1, A_STB = 4'd2, A_HLD = 4'd3, GAP = 4'd4,
                         D_SET = 4'd5, D_STB = 4'd6, D_HLD = 4'd7, DONE = 4'd8;
  localparam int TM1 = T_SETUP > T_STROBE ? T_SETUP : T_STROBE;
  localparam int TM2 = T_HOLD > T_GAP ? T_HOLD : T_GAP;
  localparam int TMAX = TM1 > TM2 ? TM1 : TM2;
  localparam int CW = $clog2(TMAX + 1);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [3:0]        state, nxt;
  logic [CW-1:0]     cnt, nxt_len;
  logic [NUM_CH-1:0] grant;
  logic [DW-1:0]     addr_q, wdata_q, rdata, a_sel, d_sel;
  logic              rnw_q, r_sel, found, in_a, in_d;
  logic [PW-1:0]     win, c;
`ifdef RTC_RR_ARB_EN
  logic [PW-1:0]     ptr;
`endif
  always_comb begin
    win = '0;
    c = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef RTC_RR_ARB_EN
      c = PW'((int'(ptr) + i) % NUM_CH);
`else
      c = PW'(i);
`endif
      if (!found && bus.req[c]) begin
        win = c;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    a_sel = '0;
    d_sel = '0;
    r_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == PW'(i)) begin
        a_sel = bus.addr_in[i*DW +: DW];
        d_sel = bus.wdata_in[i*DW +: DW];
        r_sel = bus.rnw[i];
      end
    end
  end
  assign nxt = state + 4'd1;
  assign nxt_len = (nxt == A_STB || nxt == D_STB) ? CW'(T_STROBE - 1) :
                   (nxt == A_HLD || nxt == D_HLD) ? CW'(T_HOLD - 1) :
                   nxt == GAP ? CW'(T_GAP - 1) :
                   nxt == D_SET ? CW'(T_SETUP - 1) : '0;
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      grant <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rnw_q <= 1'b0;
      rdata <= '0;
`ifdef RTC_RR_ARB_EN
      ptr <= '0;
`endif
    end else begin
      if (state == IDLE) begin
        if (found) begin
          grant <= NUM_CH'(1) << win;
          addr_q <= a_sel;
          wdata_q <= d_sel;
          rnw_q <= r_sel;
          state <= A_SET;
          cnt <= CW'(T_SETUP - 1);
`ifdef RTC_RR_ARB_EN
          ptr <= (win == PW'(NUM_CH - 1)) ? '0 : win + 1'b1;
`endif
        end
      end else if (state == DONE) begin
        grant <= '0;
        state <= IDLE;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= nxt;
        cnt <= nxt_len;
      end
      // read data is taken on the last strobe cycle, just before rd_n rises
      if (state == D_STB && cnt == '0 && rnw_q) rdata <= bus.bus_in;
    end
  end
  assign in_a = state == A_SET || state == A_STB || state == A_HLD;
  assign in_d = state == D_SET || state == D_STB || state == D_HLD;
  assign bus.cs_n = !(in_a || state == GAP || in_d);
  assign bus.wr_n = !(state == A_STB || (state == D_STB && !rnw_q));
  assign bus.rd_n = !(state == D_STB && rnw_q);
  assign bus.bus_oe = in_a || (in_d && !rnw_q);
  assign bus.bus_out = in_a ? addr_q : (in_d && !rnw_q) ? wdata_q : '0;
  assign bus.aod = in_d;
  assign bus.done = state == DONE;
  assign bus.busy = |grant;
  assign bus.grant = grant;
  assign bus.rdata = rdata;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed checks of the RTC bus sequencer; cycle 1 is the IDLE cycle a request is first seen.
module tb_rtc_bus_sequencer;
  localparam int NUM_CH = 5, DW = 8;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int compared = 0, mismatched = 0;
  bit mon_en = 1'b0;
  int wr_run = 0, rd_run = 0;
  rtc_bus_sequencer_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();
  rtc_bus_sequencer #(.NUM_CH(NUM_CH), .DW(DW), .T_SETUP(1), .T_STROBE(4), .T_HOLD(1), .T_GAP(2))
    dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_all;
    bus.req = '0;
    bus.rnw = '0;
    bus.addr_in = '0;
    bus.wdata_in = '0;
    bus.bus_in = '0;
  endtask
  task automatic set_ch(input int ch, input logic r, input logic rd, input logic [7:0] a, input logic [7:0] d);
    bus.req[ch] = r;
    bus.rnw[ch] = rd;
    bus.addr_in[ch*DW +: DW] = a;
    bus.wdata_in[ch*DW +: DW] = d;
  endtask
  // protocol monitor: exclusivity of rd_n against bus_oe/wr_n, and strobe widths of 4
  initial forever begin
    @(negedge clk);
    if (Reset) begin
      wr_run = 0;
      rd_run = 0;
    end else begin
      if (mon_en) begin
        compared++;
        if (!bus.rd_n && (bus.bus_oe || !bus.wr_n)) begin
          mismatched++;
          $display("FAIL excl @%0t: rd_n=%b wr_n=%b bus_oe=%b, required rd_n low alone", $time, bus.rd_n, bus.wr_n, bus.bus_oe);
        end
      end
      if (!bus.wr_n) wr_run++;
      else begin
        if (mon_en && wr_run != 0) begin
          compared++;
          if (wr_run != 4) begin
            mismatched++;
            $display("FAIL wr_width @%0t: got %0d required 4", $time, wr_run);
          end
        end
        wr_run = 0;
      end
      if (!bus.rd_n) rd_run++;
      else begin
        if (mon_en && rd_run != 0) begin
          compared++;
          if (rd_run != 4) begin
            mismatched++;
            $display("FAIL rd_width @%0t: got %0d required 4", $time, rd_run);
          end
        end
        rd_run = 0;
      end
    end
  end
  task automatic test_reset;
    Reset = 1'b1;
    clear_all();
    tick();
    tick();
    compared++;
    if ({bus.grant, bus.done, bus.busy, bus.bus_oe, bus.aod} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_ctl: grant/done/busy/oe/aod=%b required 0", {bus.grant, bus.done, bus.busy, bus.bus_oe, bus.aod});
    end
    compared++;
    if ({bus.cs_n, bus.rd_n, bus.wr_n} !== 3'b111) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b required 111", {bus.cs_n, bus.rd_n, bus.wr_n});
    end
    compared++;
    if ({bus.rdata, bus.bus_out} !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_data: rdata=%h bus_out=%h required 00", bus.rdata, bus.bus_out);
    end
    Reset = 1'b0;
    tick();
    compared++;
    if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_no_req: cs_n=%b busy=%b required 1 0", bus.cs_n, bus.busy);
    end
    mon_en = 1'b1;
  endtask
  task automatic test_write;
    int done_at = 0, wr_a = 0, wr_d = 0, bad = 0, cs_low = 0, oe_d = 0;
    logic [4:0] g2 = '0;
    logic busy16 = 1'b0;
    set_ch(2, 1'b1, 1'b0, 8'h21, 8'h45);
    for (int k = 1; k <= 17; k++) begin
      if (k == 2) g2 = bus.grant;
      if (k == 3) bus.req[2] = 1'b0;
      if (k == 16) busy16 = bus.busy;
      if (bus.done && done_at == 0) done_at = k;
      if (!bus.wr_n) begin
        if (bus.aod) wr_d++;
        else wr_a++;
      end
      if (bus.bus_oe && bus.aod) oe_d++;
      if (bus.bus_oe && bus.bus_out !== (bus.aod ? 8'h45 : 8'h21)) bad++;
      if (!bus.cs_n) cs_low++;
      tick();
    end
    compared++;
    if (g2 !== 5'b00100) begin mismatched++; $display("FAIL wr_grant: got %b required 00100", g2); end
    compared++;
    if (done_at !== 16) begin mismatched++; $display("FAIL wr_latency: done at cycle %0d required 16", done_at); end
    compared++;
    if (wr_a !== 4 || wr_d !== 4) begin mismatched++; $display("FAIL wr_strobes: addr %0d data %0d required 4 4", wr_a, wr_d); end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL wr_bus_value: %0d wrong cycles required 0", bad); end
    compared++;
    if (cs_low !== 14 || oe_d !== 6) begin mismatched++; $display("FAIL wr_cs_oe: cs low %0d oe data %0d required 14 6", cs_low, oe_d); end
    compared++;
    if (busy16 !== 1'b1 || bus.busy !== 1'b0 || bus.grant !== 5'b0) begin
      mismatched++;
      $display("FAIL wr_release: busy@16=%b busy=%b grant=%b required 1 0 00000", busy16, bus.busy, bus.grant);
    end
  endtask
  task automatic test_read;
    int done_at = 0, rd_first = 0, rd_cnt = 0, oe_d = 0, wr_cnt = 0;
    logic [7:0] rd_at_done = '0;
    logic [4:0] g2 = '0;
    set_ch(1, 1'b1, 1'b1, 8'h22, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      bus.bus_in = (k >= 11 && k <= 14) ? 8'h37 : 8'hAA;
      if (k == 2) g2 = bus.grant;
      if (k == 3) bus.req[1] = 1'b0;
      if (bus.done && done_at == 0) begin done_at = k; rd_at_done = bus.rdata; end
      if (!bus.rd_n) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = k;
      end
      if (!bus.wr_n) wr_cnt++;
      if (bus.bus_oe && bus.aod) oe_d++;
      tick();
    end
    compared++;
    if (g2 !== 5'b00010) begin mismatched++; $display("FAIL rd_grant: got %b required 00010", g2); end
    compared++;
    if (rd_first !== 11 || rd_cnt !== 4) begin mismatched++; $display("FAIL rd_strobe: first %0d count %0d required 11 4", rd_first, rd_cnt); end
    compared++;
    if (oe_d !== 0 || wr_cnt !== 4) begin mismatched++; $display("FAIL rd_oe: oe data %0d wr low %0d required 0 4", oe_d, wr_cnt); end
    compared++;
    if (done_at !== 16 || rd_at_done !== 8'h37) begin
      mismatched++;
      $display("FAIL rd_done: cycle %0d rdata %h required 16 37", done_at, rd_at_done);
    end
    compared++;
    if (bus.rdata !== 8'h37) begin mismatched++; $display("FAIL rd_hold: got %h required 37", bus.rdata); end
  endtask
  task automatic test_priority;
    logic [4:0] exp [3];
    logic [4:0] gv [3];
    int gk [3];
    int n = 0;
    logic [4:0] prev = '0;
`ifdef RTC_RR_ARB_EN
    exp = '{5'b00001, 5'b01000, 5'b00001};
`else
    exp = '{5'b00001, 5'b00001, 5'b00001};
`endif
    Reset = 1'b1;
    clear_all();
    tick();
    Reset = 1'b0;
    set_ch(0, 1'b1, 1'b0, 8'h10, 8'h01);
    set_ch(3, 1'b1, 1'b0, 8'h30, 8'h03);
    for (int k = 1; k <= 48; k++) begin
      if (bus.grant != 0 && prev == 0 && n < 3) begin
        gv[n] = bus.grant;
        gk[n] = k;
        n++;
      end
      prev = bus.grant;
      tick();
    end
    clear_all();
    compared++;
    if (n !== 3) begin mismatched++; $display("FAIL prio_count: got %0d grants required 3", n); end
    for (int i = 0; i < n; i++) begin
      compared++;
      // each arbitration cycle is cycle 17 of the previous transaction
      if (gv[i] !== exp[i] || gk[i] !== 2 + 16 * i) begin
        mismatched++;
        $display("FAIL prio_grant%0d: got %b at %0d required %b at %0d", i, gv[i], gk[i], exp[i], 2 + 16 * i);
      end
    end
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    tick();
  endtask
  task automatic test_reset_abort;
    int done_seen = 0;
    set_ch(2, 1'b1, 1'b0, 8'h21, 8'h45);
    for (int k = 1; k <= 11; k++) begin
      if (k == 3) bus.req[2] = 1'b0;
      tick();
    end
    compared++;
    if (bus.wr_n !== 1'b0 || bus.aod !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_pre: wr_n=%b aod=%b required 0 1", bus.wr_n, bus.aod);
    end
    Reset = 1'b1;
    tick();
    compared++;
    if ({bus.cs_n, bus.wr_n, bus.bus_oe, bus.busy} !== 4'b1100 || bus.grant !== 5'b0) begin
      mismatched++;
      $display("FAIL abort_release: cs_n/wr_n/oe/busy=%b grant=%b required 1100 00000", {bus.cs_n, bus.wr_n, bus.bus_oe, bus.busy}, bus.grant);
    end
    Reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) done_seen++;
      tick();
    end
    compared++;
    if (done_seen !== 0) begin mismatched++; $display("FAIL abort_done: %0d pulses required 0", done_seen); end
  endtask
  task automatic test_addr_change;
    int a1 = 0, a2 = 0, bad = 0, n = 0, nd = 0;
    int gk [2];
    int dk [2];
    logic [4:0] prev = '0;
    set_ch(4, 1'b1, 1'b0, 8'h11, 8'h99);
    for (int k = 1; k <= 33; k++) begin
      if (k == 3) bus.addr_in[4*DW +: DW] = 8'h5A;
      if (k == 19) bus.req[4] = 1'b0;
      if (bus.grant != 0 && prev == 0 && n < 2) begin gk[n] = k; n++; end
      if (bus.done && nd < 2) begin dk[nd] = k; nd++; end
      prev = bus.grant;
      if (bus.bus_oe && !bus.aod) begin
        if (k < 17) begin a1++; if (bus.bus_out !== 8'h11) bad++; end
        else begin a2++; if (bus.bus_out !== 8'h5A) bad++; end
      end
      tick();
    end
    compared++;
    if (bad !== 0 || a1 !== 6 || a2 !== 6) begin
      mismatched++;
      $display("FAIL addr_capture: bad %0d cycles a1 %0d a2 %0d required 0 6 6", bad, a1, a2);
    end
    compared++;
    if (n !== 2 || gk[0] !== 2 || gk[1] !== 18) begin
      mismatched++;
      $display("FAIL addr_regrant: %0d grants at %0d,%0d required 2 at 2,18", n, gk[0], gk[1]);
    end
    compared++;
    if (nd !== 2 || dk[0] !== 16 || dk[1] !== 32) begin
      mismatched++;
      $display("FAIL addr_done: %0d done at %0d,%0d required 2 at 16,32", nd, dk[0], dk[1]);
    end
    clear_all();
    tick();
  endtask
  task automatic test_protocol;
    logic [63:0] r;
    int nd = 0;
    for (int k = 0; k < 700; k++) begin
      bus.req = NUM_CH'($urandom_range(0, 31) & $urandom_range(0, 31));
      bus.rnw = NUM_CH'($urandom_range(0, 31));
      r = {$urandom(), $urandom()};
      bus.addr_in = r[NUM_CH*DW-1:0];
      r = {$urandom(), $urandom()};
      bus.wdata_in = r[NUM_CH*DW-1:0];
      bus.bus_in = DW'($urandom_range(0, 255));
      if (bus.done) nd++;
      tick();
    end
    bus.req = '0;
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL proto_drain: busy=%b required 0", bus.busy); end
    compared++;
    if (nd < 20) begin mismatched++; $display("FAIL proto_traffic: %0d transactions required >=20", nd); end
  endtask
  initial begin
    clear_all();
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_reset_abort();
    test_addr_change();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
